// File: rtl/circuit7_sched_pkg.sv
// Shared types and constants for the circuit7 divide/modulo/compare/select sequencer.
package circuit7_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_AB = 3'd1,
    RUN_AB  = 3'd2,
    FIX_AB  = 3'd3,
    LOAD_CD = 3'd4,
    RUN_CD  = 3'd5,
    FIX_CD  = 3'd6,
    WRITE   = 3'd7
  } state_t;

  // Quotient returned for a zero divisor; sliced down to the operand width.
  localparam int MAX_DATAWIDTH = 256;
  localparam logic [MAX_DATAWIDTH-1:0] DIV0_QUOT = '1;

  function automatic int LAT_FULL(input int w);
    return 2 * w + 5;
  endfunction

  function automatic int LAT_SKIP(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/circuit7_sched_sdiv_iter.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per cycle.
// load captures magnitudes and signs; quot/rem present the sign-corrected result.
module sdiv_iter
  import circuit7_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 dz
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  logic [DATAWIDTH-1:0] rem_reg;
  logic [DATAWIDTH-1:0] quo_reg;   // dividend bits shift out as quotient bits shift in
  logic [DATAWIDTH-1:0] dvs_reg;
  logic                 neg_n_reg;
  logic                 neg_d_reg;
  logic [CW-1:0]        cnt_reg;

  logic [DATAWIDTH:0]   shifted;
  logic [DATAWIDTH:0]   trial;

  always_comb begin
    shifted = {rem_reg, quo_reg[DATAWIDTH-1]};
    trial   = shifted - {1'b0, dvs_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      neg_n_reg <= 1'b0;
      neg_d_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (load) begin
      rem_reg   <= '0;
      quo_reg   <= dividend[DATAWIDTH-1] ? -dividend : dividend;
      dvs_reg   <= divisor[DATAWIDTH-1] ? -divisor : divisor;
      neg_n_reg <= dividend[DATAWIDTH-1];
      neg_d_reg <= divisor[DATAWIDTH-1];
      cnt_reg   <= CW'(DATAWIDTH);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
      if (!trial[DATAWIDTH]) begin
        rem_reg <= trial[DATAWIDTH-1:0];
        quo_reg <= {quo_reg[DATAWIDTH-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[DATAWIDTH-1:0];
        quo_reg <= {quo_reg[DATAWIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor leaves rem = |dividend|, so only the quotient needs overriding.
  always_comb begin
    dz   = (dvs_reg == '0);
    quot = dz ? DIV0_QUOT[DATAWIDTH-1:0]
              : ((neg_n_reg ^ neg_d_reg) ? -quo_reg : quo_reg);
    rem  = neg_n_reg ? -rem_reg : rem_reg;
  end

endmodule

// File: rtl/circuit7_sched.sv
// Sequencer computing z = (a % b == zero) ? c / d : a / b on one shared iterative divider.
// Define CIRCUIT7_SCHED_SKIP_EN to skip the c/d division when the compare fails.
module circuit7_sched
  import circuit7_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] z,
  output logic                 div0
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  state_t               state_reg;
  logic [DATAWIDTH-1:0] a_reg, b_reg, c_reg, d_reg, zero_reg;
  logic [DATAWIDTH-1:0] q_ab_reg, q_cd_reg, z_reg;
  logic                 geqz_reg;
  logic                 busy_reg, done_reg, div0_reg;
  logic [CW-1:0]        cnt_reg;

  logic                 div_load;
  logic [DATAWIDTH-1:0] div_dividend, div_divisor, div_quot, div_rem;
  logic                 div_dz;

  assign div_load     = (state_reg == LOAD_AB) || (state_reg == LOAD_CD);
  assign div_dividend = (state_reg == LOAD_CD) ? c_reg : a_reg;
  assign div_divisor  = (state_reg == LOAD_CD) ? d_reg : b_reg;

  sdiv_iter #(.DATAWIDTH(DATAWIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quot     (div_quot),
    .rem      (div_rem),
    .dz       (div_dz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      zero_reg  <= '0;
      q_ab_reg  <= '0;
      q_cd_reg  <= '0;
      z_reg     <= '0;
      geqz_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      div0_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            c_reg     <= c;
            d_reg     <= d;
            zero_reg  <= zero;
            div0_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= LOAD_AB;
          end
        end
        LOAD_AB: begin
          cnt_reg   <= CW'(DATAWIDTH - 1);
          state_reg <= RUN_AB;
        end
        RUN_AB: begin
          if (cnt_reg == '0) state_reg <= FIX_AB;
          else               cnt_reg   <= cnt_reg - CW'(1);
        end
        FIX_AB: begin
          q_ab_reg  <= div_quot;
          geqz_reg  <= (div_rem == zero_reg);
          if (div_dz) div0_reg <= 1'b1;
          state_reg <= LOAD_CD;
        end
        LOAD_CD: begin
          cnt_reg <= CW'(DATAWIDTH - 1);
`ifdef CIRCUIT7_SCHED_SKIP_EN
          // The compare result is registered on leaving FIX_AB, so the skip is decided here.
          state_reg <= geqz_reg ? RUN_CD : WRITE;
`else
          state_reg <= RUN_CD;
`endif
        end
        RUN_CD: begin
          if (cnt_reg == '0) state_reg <= FIX_CD;
          else               cnt_reg   <= cnt_reg - CW'(1);
        end
        FIX_CD: begin
          q_cd_reg  <= div_quot;
          if (div_dz) div0_reg <= 1'b1;
          state_reg <= WRITE;
        end
        WRITE: begin
          z_reg     <= geqz_reg ? q_cd_reg : q_ab_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign z    = z_reg;
  assign div0 = div0_reg;

endmodule
